// File: rtl/zbuf_pkg.sv
// Shared z-buffer types: depth compare functions, scheduler FSM states
// and a saturating increment helper for the statistics counters.
package zbuf_pkg;

    typedef enum logic [2:0] {
        NEVER    = 3'b000,
        LESS     = 3'b001,
        EQUAL    = 3'b010,
        LEQUAL   = 3'b011,
        GREATER  = 3'b100,
        NOTEQUAL = 3'b101,
        GEQUAL   = 3'b110,
        ALWAYS   = 3'b111
    } z_func_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_EMIT,
        S_FL_ISSUE,
        S_FL_WAIT
    } zsched_state_t;

    localparam int STAT_W = 16;

    function automatic logic [STAT_W-1:0] sat_inc(
        input logic [STAT_W-1:0] v
    );
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/z_test_scheduler_if.sv
// Depth-unit bus: start/flush request with operands (master side),
// done/pass result (slave side). Operands hold until done.
interface z_test_scheduler_if #(
    parameter int Z_SIZE       = 8,
    parameter int X_PIXEL_SIZE = 2,
    parameter int Y_PIXEL_SIZE = 2
);
    import zbuf_pkg::*;

    logic                    start;
    logic                    flush;
    logic [X_PIXEL_SIZE-1:0] x;
    logic [Y_PIXEL_SIZE-1:0] y;
    logic [Z_SIZE-1:0]       z;
    z_func_t                 func;
    logic                    done;
    logic                    pass;

    modport master (
        output start, flush, x, y, z, func,
        input  done, pass
    );

    modport slave (
        input  start, flush, x, y, z, func,
        output done, pass
    );

endinterface

// File: rtl/zsched_frag_fifo.sv
// Synchronous fragment FIFO. Ports: clk, rst, push/wdata, pop/rdata,
// full, empty. Pointers carry an extra wrap bit to tell full from empty.
module zsched_frag_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rdata = mem[rd_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/z_test_scheduler.sv
// Z-test scheduler: queues fragments, issues one depth op at a time over
// the zb bus, forwards passing fragments, orders z-buffer flushes after
// earlier fragments. Ports: clk_i/rst_i, frag_* input stream, flush
// req/ack, zb depth-unit bus, out_* stream, busy_o. Define
// ZSCHED_STATS_EN for stats_clr_i / pass_cnt_o / kill_cnt_o counters.
module z_test_scheduler
    import zbuf_pkg::*;
#(
    parameter int Z_SIZE       = 8,
    parameter int X_PIXEL_SIZE = 2,
    parameter int Y_PIXEL_SIZE = 2,
    parameter int COLOR_SIZE   = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    frag_valid_i,
    output logic                    frag_ready_o,
    input  logic [X_PIXEL_SIZE-1:0] frag_x_i,
    input  logic [Y_PIXEL_SIZE-1:0] frag_y_i,
    input  logic [Z_SIZE-1:0]       frag_z_i,
    input  logic [COLOR_SIZE-1:0]   frag_color_i,
    input  logic [2:0]              z_depth_func_i,
    input  logic                    flush_req_i,
    output logic                    flush_ack_o,
    z_test_scheduler_if.master      zb,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [X_PIXEL_SIZE-1:0] out_x_o,
    output logic [Y_PIXEL_SIZE-1:0] out_y_o,
    output logic [COLOR_SIZE-1:0]   out_color_o,
    output logic                    busy_o
`ifdef ZSCHED_STATS_EN
    ,
    input  logic                    stats_clr_i,
    output logic [STAT_W-1:0]       pass_cnt_o,
    output logic [STAT_W-1:0]       kill_cnt_o
`endif
);
    localparam int W = X_PIXEL_SIZE + Y_PIXEL_SIZE + Z_SIZE
                     + 3 + COLOR_SIZE;

    zsched_state_t state_q, state_d;

    logic [W-1:0]            head;
    logic                    full, empty, push, pop, load;
    logic [X_PIXEL_SIZE-1:0] h_x;
    logic [Y_PIXEL_SIZE-1:0] h_y;
    logic [Z_SIZE-1:0]       h_z;
    logic [2:0]              h_func;
    logic [COLOR_SIZE-1:0]   h_color;
    logic                    op_act;

    // Async reset also forces ready low so every output reads 0 in reset.
    assign frag_ready_o = !rst_i && !full && !flush_req_i;
    assign push = frag_valid_i && frag_ready_o;

    zsched_frag_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .wdata ({frag_x_i, frag_y_i, frag_z_i,
                 z_depth_func_i, frag_color_i}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign {h_x, h_y, h_z, h_func, h_color} = head;

    // Head stays in the FIFO until done, so operands are stable in WAIT.
    assign op_act  = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign zb.x    = op_act ? h_x : '0;
    assign zb.y    = op_act ? h_y : '0;
    assign zb.z    = op_act ? h_z : '0;
    assign zb.func = op_act ? z_func_t'(h_func) : NEVER;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        zb.start    = 1'b0;
        zb.flush    = 1'b0;
        pop         = 1'b0;
        load        = 1'b0;
        flush_ack_o = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty)           state_d = S_ISSUE;
                else if (flush_req_i) state_d = S_FL_ISSUE;
            end
            S_ISSUE: begin
                zb.start = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (zb.done) begin
                    pop     = 1'b1;
                    load    = zb.pass;
                    state_d = zb.pass ? S_EMIT : S_IDLE;
                end
            end
            S_EMIT: begin
                if (out_ready_i) state_d = S_IDLE;
            end
            S_FL_ISSUE: begin
                zb.start = 1'b1;
                zb.flush = 1'b1;
                state_d  = S_FL_WAIT;
            end
            S_FL_WAIT: begin
                if (zb.done) begin
                    flush_ack_o = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_x_o     <= '0;
            out_y_o     <= '0;
            out_color_o <= '0;
        end else if (load) begin
            out_x_o     <= h_x;
            out_y_o     <= h_y;
            out_color_o <= h_color;
        end
    end

    assign out_valid_o = (state_q == S_EMIT);
    assign busy_o      = !empty || (state_q != S_IDLE);

`ifdef ZSCHED_STATS_EN
    logic cnt_pass, cnt_kill;

    assign cnt_pass = (state_q == S_WAIT) && zb.done && zb.pass;
    assign cnt_kill = (state_q == S_WAIT) && zb.done && !zb.pass;

    // A result landing in the clear cycle still counts.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pass_cnt_o <= '0;
            kill_cnt_o <= '0;
        end else begin
            if (cnt_pass)         pass_cnt_o <= sat_inc(pass_cnt_o);
            else if (stats_clr_i) pass_cnt_o <= '0;
            if (cnt_kill)         kill_cnt_o <= sat_inc(kill_cnt_o);
            else if (stats_clr_i) kill_cnt_o <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_z_test_scheduler.sv
// Self-checking bench for z_test_scheduler: depth-unit responder model,
// issue-order and output scoreboards, one task per scenario.
module tb_z_test_scheduler;
    import zbuf_pkg::*;

    typedef struct {
        logic [1:0]  x;
        logic [1:0]  y;
        logic [7:0]  z;
        logic [2:0]  f;
        logic [15:0] c;
        logic        fl;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frag_valid = 1'b0;
    logic        frag_ready;
    logic [1:0]  frag_x = '0;
    logic [1:0]  frag_y = '0;
    logic [7:0]  frag_z = '0;
    logic [15:0] frag_color = '0;
    logic [2:0]  frag_func = '0;
    logic        flush_req = 1'b0;
    logic        flush_ack;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_x;
    logic [1:0]  out_y;
    logic [15:0] out_color;
    logic        busy;
`ifdef ZSCHED_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] pass_cnt;
    logic [15:0] kill_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;
    int out_cnt = 0;
    int lat = 2;
    bit stall = 1'b0;

    ent_t iq[$];
    ent_t exp_q[$];

    z_test_scheduler_if #(
        .Z_SIZE(8), .X_PIXEL_SIZE(2), .Y_PIXEL_SIZE(2)
    ) zb ();

    z_test_scheduler #(
        .Z_SIZE(8), .X_PIXEL_SIZE(2), .Y_PIXEL_SIZE(2),
        .COLOR_SIZE(16), .FIFO_DEPTH(4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .frag_valid_i   (frag_valid),
        .frag_ready_o   (frag_ready),
        .frag_x_i       (frag_x),
        .frag_y_i       (frag_y),
        .frag_z_i       (frag_z),
        .frag_color_i   (frag_color),
        .z_depth_func_i (frag_func),
        .flush_req_i    (flush_req),
        .flush_ack_o    (flush_ack),
        .zb             (zb),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_x_o        (out_x),
        .out_y_o        (out_y),
        .out_color_o    (out_color),
        .busy_o         (busy)
`ifdef ZSCHED_STATS_EN
        ,
        .stats_clr_i    (stats_clr),
        .pass_cnt_o     (pass_cnt),
        .kill_cnt_o     (kill_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Depth-unit model: stored depth is 0x80 everywhere, func LESS rule.
    initial begin
        ent_t e;
        logic [7:0] pz;
        int n;
        bit abort;
        zb.done = 1'b0;
        zb.pass = 1'b0;
        forever begin
            @(negedge clk);
            if (zb.start === 1'b1) begin
                start_cnt++;
                pz = zb.z;
                checks++;
                if (iq.size() == 0) begin
                    errors++;
                    $display("FAIL issue_unexpected got start, want none");
                end else begin
                    e = iq.pop_front();
                    if (e.fl) begin
                        if (zb.flush !== 1'b1) begin
                            errors++;
                            $display("FAIL issue_flush got %b want 1",
                                     zb.flush);
                        end
                    end else if ({zb.flush, zb.x, zb.y, zb.z, zb.func}
                                 !== {1'b0, e.x, e.y, e.z, e.f}) begin
                        errors++;
                        $display("FAIL issue_ops got %b/%h/%h/%h/%h want 0/%h/%h/%h/%h",
                                 zb.flush, zb.x, zb.y, zb.z, zb.func,
                                 e.x, e.y, e.z, e.f);
                    end
                end
                n = 0;
                abort = 1'b0;
                do begin
                    @(posedge clk); #1;
                    if (rst) abort = 1'b1;
                    n++;
                end while (!abort && (stall || n < lat));
                if (!abort) begin
                    zb.pass = (pz < 8'h80);
                    zb.done = 1'b1;
                    @(posedge clk); #1;
                    zb.done = 1'b0;
                    zb.pass = 1'b0;
                end
            end
        end
    end

    // Output scoreboard.
    always @(negedge clk) begin
        ent_t e;
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected got x=%h y=%h c=%h want none",
                         out_x, out_y, out_color);
            end else begin
                e = exp_q.pop_front();
                out_cnt++;
                if ({out_x, out_y, out_color} !== {e.x, e.y, e.c}) begin
                    errors++;
                    $display("FAIL out_payload got %h/%h/%h want %h/%h/%h",
                             out_x, out_y, out_color, e.x, e.y, e.c);
                end
            end
        end
    end

    task automatic send(input logic [1:0] x, input logic [1:0] y,
                        input logic [7:0] z, input logic [15:0] c);
        ent_t e;
        int n = 0;
        e.x = x; e.y = y; e.z = z; e.f = LESS; e.c = c; e.fl = 1'b0;
        frag_valid = 1'b1;
        frag_x = x; frag_y = y; frag_z = z;
        frag_color = c; frag_func = LESS;
        forever begin
            @(negedge clk);
            if (frag_ready) break;
            n++;
            if (n > 300) break;
        end
        if (n > 300) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got ready=0 want 1");
        end else begin
            iq.push_back(e);
            if (z < 8'h80) exp_q.push_back(e);
        end
        @(posedge clk); #1;
        frag_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0 || iq.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL idle_timeout got busy=%b pend=%0d want 0/0",
                     busy, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, zb.start, zb.flush, busy, flush_ack, frag_ready,
             out_x, out_y, out_color} !== '0) begin
            errors++;
            $display("FAIL reset_outs got v=%b s=%b b=%b r=%b want 0",
                     out_valid, zb.start, busy, frag_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (frag_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got r=%b b=%b want 1/0",
                     frag_ready, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int s0 = start_cnt;
        int o0 = out_cnt;
        send(2'd1, 2'd2, 8'h10, 16'hABCD);
        wait_idle();
        checks++;
        if (start_cnt - s0 != 1 || out_cnt - o0 != 1) begin
            errors++;
            $display("FAIL single_counts got s=%0d o=%0d want 1/1",
                     start_cnt - s0, out_cnt - o0);
        end
    endtask

    task automatic test_kill();
        int o0 = out_cnt;
        send(2'd3, 2'd0, 8'hF0, 16'h0BAD);
        wait_idle();
        checks++;
        if (out_cnt != o0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL kill_drop got outs=%0d busy=%b want 0/0",
                     out_cnt - o0, busy);
        end
`ifdef ZSCHED_STATS_EN
        checks++;
        if (kill_cnt !== 16'd1 || pass_cnt !== 16'd1) begin
            errors++;
            $display("FAIL kill_stats got k=%0d p=%0d want 1/1",
                     kill_cnt, pass_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int o0 = out_cnt;
        stall = 1'b1;
        for (int i = 0; i < 4; i++)
            send(2'(i), 2'(3 - i), 8'(8'h20 + i), 16'(16'h1000 + i));
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (frag_ready !== 1'b0) begin
                errors++;
                $display("FAIL full_ready got %b want 0", frag_ready);
            end
        end
        @(posedge clk); #1;
        fork
            send(2'd1, 2'd1, 8'h7F, 16'h1004);
            begin
                repeat (5) @(posedge clk);
                #1 stall = 1'b0;
            end
        join
        wait_idle();
        checks++;
        if (out_cnt - o0 != 5) begin
            errors++;
            $display("FAIL b2b_count got %0d want 5", out_cnt - o0);
        end
    endtask

    task automatic test_flush();
        ent_t f;
        int o0 = out_cnt;
        int n = 0;
        int acks = 0;
        f.x = '0; f.y = '0; f.z = '0; f.f = '0; f.c = '0; f.fl = 1'b1;
        stall = 1'b1;
        send(2'd0, 2'd1, 8'h05, 16'h2222);
        send(2'd2, 2'd2, 8'h06, 16'h3333);
        flush_req = 1'b1;
        iq.push_back(f);
        while (acks == 0 && n < 300) begin
            @(negedge clk);
            n++;
            if (n == 4) stall = 1'b0;
            if (flush_ack === 1'b1) acks++;
            checks++;
            if (frag_ready !== 1'b0) begin
                errors++;
                $display("FAIL flush_ready got %b want 0", frag_ready);
            end
        end
        checks++;
        if (acks != 1 || out_cnt - o0 != 2) begin
            errors++;
            $display("FAIL flush_order got ack=%0d outs=%0d want 1/2",
                     acks, out_cnt - o0);
        end
        @(posedge clk); #1;
        flush_req = 1'b0;
        @(negedge clk);
        checks++;
        if (flush_ack !== 1'b0) begin
            errors++;
            $display("FAIL flush_pulse got %b want 0", flush_ack);
        end
        wait_idle();
    endtask

    task automatic test_emit_stall();
        int n = 0;
        int s0;
        out_ready = 1'b0;
        send(2'd3, 2'd1, 8'h20, 16'h1234);
        send(2'd2, 2'd3, 8'h30, 16'h5678);
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        s0 = start_cnt;
        repeat (10) begin
            @(negedge clk);
            checks++;
            if ({out_valid, out_x, out_y, out_color}
                !== {1'b1, 2'd3, 2'd1, 16'h1234} || start_cnt != s0) begin
                errors++;
                $display("FAIL emit_hold got %b/%h/%h/%h st=%0d want 1/3/1/1234 st=%0d",
                         out_valid, out_x, out_y, out_color,
                         start_cnt, s0);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_idle();
    endtask

    task automatic test_reset_wait();
        int s0 = start_cnt;
        int o0;
        int n = 0;
        stall = 1'b1;
        send(2'd3, 2'd2, 8'h40, 16'h4444);
        send(2'd1, 2'd3, 8'h41, 16'h5555);
        while (start_cnt == s0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({zb.start, zb.flush, zb.x, zb.y, zb.z, zb.func, out_valid,
             busy, flush_ack, frag_ready} !== '0) begin
            errors++;
            $display("FAIL rst_wait_outs got x=%h z=%h b=%b r=%b want 0",
                     zb.x, zb.z, busy, frag_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        iq.delete();
        exp_q.delete();
        stall = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || frag_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_empty got b=%b r=%b want 0/1",
                     busy, frag_ready);
        end
        @(posedge clk); #1;
        o0 = out_cnt;
        send(2'd2, 2'd0, 8'h11, 16'h6666);
        wait_idle();
        checks++;
        if (out_cnt - o0 != 1) begin
            errors++;
            $display("FAIL rst_wait_resume got %0d want 1", out_cnt - o0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_kill();
        test_back_to_back();
        test_flush();
        test_emit_stall();
        test_reset_wait();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover got %0d want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
